// File: rtl/if_fetch.sv
// Instruction-fetch stage: program counter plus a single-outstanding req/ack port to instruction
// memory, presenting each fetched word and its PC to the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        cpu_stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        advance;
  logic        redirect;
  logic [31:0] pc_next;
  logic [31:0] target;

  assign advance  = ~stall_i & ~cpu_stall_i;
  assign redirect = branch_taken_i & advance;
  assign pc_next  = pc_q + 32'd4;
  assign target   = {branch_target_i[31:2], 2'b00};
  assign pc_o     = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    drain_addr_d  = drain_addr_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = pc_q;
    instr_o       = 32'h0;
    instr_valid_o = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect) begin
          pc_d = target;
          // An in-flight request must complete before the new address can be issued.
          if (!imem_ack_i) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack_i && advance) begin
          instr_o       = imem_data_i;
          instr_valid_o = 1'b1;
          pc_d          = pc_next;
        end else if (imem_ack_i) begin
          buf_d   = imem_data_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else begin
          instr_o       = buf_q;
          instr_valid_o = 1'b1;
          if (advance) begin
            pc_d    = pc_next;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        if (redirect) pc_d = target;
        if (imem_ack_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      buf_q        <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory model returning word = address with programmable latency, and a
// scoreboard of the PCs the IF/ID register is expected to capture.
module tb_if_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        cpu_stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int          lat = 0;
  int          mem_cnt;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;
  int          bubble_run = 0;
  int          last_run = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  if_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .cpu_stall_i     (cpu_stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: acks after lat waiting cycles of a request; word equals address.
  assign imem_ack_i  = imem_req_o && (mem_cnt == lat);
  assign imem_data_i = imem_addr_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_cnt <= 0;
    else if (imem_req_o && !imem_ack_i) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every word IF/ID captures must be the next expected one.
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (rst_i) begin
      prev_pend  = 1'b0;
      bubble_run = 0;
    end else begin
      if (prev_pend && imem_req_o) check("addr_stable", imem_addr_o, prev_addr);
      prev_pend = imem_req_o && !imem_ack_i;
      prev_addr = imem_addr_o;
      if (!stall_i && !cpu_stall_i) begin
        if (instr_valid_o) begin
          if (sb_q.size() == 0) begin
            check("spurious_capture", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("cap_pc", pc_o, e);
            check("cap_instr", instr_o, e);
          end
          last_run   = bubble_run;
          bubble_run = 0;
        end else begin
          check("bubble_word", instr_o, 32'h0);
          bubble_run++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_n(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Runs until the scoreboard is empty, then freezes the pipe with stall_i.
  task automatic run_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (sb_q.size() == 0) begin
        stall_i = 1'b1;
        return;
      end
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    stall_i = 1'b1;
  endtask

  task automatic settle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!imem_req_o) return;
      step();
    end
    check("settle_timeout", {31'h0, imem_req_o}, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; cpu_stall_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = 32'h0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req", {31'h0, imem_req_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h100);
    check("rst_pc", pc_o, 32'h100);
    check("rst_instr", instr_o, 32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    rst_i = 1'b0;

    // Zero-wait: one instruction per cycle
    exp_pc = 32'h100;
    expect_n(3);
    run_drain(10);
    check("zw_bubbles", 32'(last_run), 32'd0);
    settle(10);

    // Three-cycle latency: three bubbles before each word
    lat = 3;
    expect_n(3);
    stall_i = 1'b0;
    run_drain(30);
    check("lat3_bubbles", 32'(last_run), 32'd3);
    settle(10);

    // cpu_stall for 4 cycles with the ack in the second
    lat = 1;
    expect_n(1);
    stall_i = 1'b0;
    step();
    cpu_stall_i = 1'b1;
    step();
    step();
    check("hold_req", {31'h0, imem_req_o}, 32'h0);
    check("hold_valid", {31'h0, instr_valid_o}, 32'h1);
    check("hold_instr", instr_o, 32'h11C);
    step();
    check("hold_instr2", instr_o, 32'h11C);
    step();
    cpu_stall_i = 1'b0;
    expect_n(1);
    step();
    check("hold_pc_adv", pc_o, 32'h120);
    check("hold_once", 32'(sb_q.size()), 32'd0);
    stall_i = 1'b1;
    settle(10);

    // Redirect while a 3-cycle request is in flight
    lat = 3;
    expect_n(1);
    stall_i = 1'b0;
    step();
    branch_taken_i = 1'b1; branch_target_i = 32'h203;
    exp_pc = 32'h200;
    expect_n(1);
    step();
    branch_taken_i = 1'b0;
    check("drain_pc", pc_o, 32'h200);
    check("drain_req", {31'h0, imem_req_o}, 32'h1);
    check("drain_addr1", imem_addr_o, 32'h124);
    step();
    check("drain_addr2", imem_addr_o, 32'h124);
    step();
    check("drain_addr3", imem_addr_o, 32'h124);
    step();
    check("redir_addr", imem_addr_o, 32'h200);
    check("redir_pc", pc_o, 32'h200);
    run_drain(20);
    settle(10);

    // Branch ignored under stall, taken a cycle later
    lat = 0;
    branch_taken_i = 1'b1; branch_target_i = 32'h300;
    step();
    check("stall_branch_pc", pc_o, 32'h204);
    stall_i = 1'b0;
    exp_pc = 32'h300;
    expect_n(2);
    step();
    branch_taken_i = 1'b0;
    check("late_branch_pc", pc_o, 32'h300);
    run_drain(10);
    settle(10);

    // PC wrap past 0xFFFF_FFFC
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
    stall_i = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    expect_n(3);
    step();
    branch_taken_i = 1'b0;
    run_drain(10);
    settle(10);

    // Asynchronous reset in the middle of a request
    lat = 3;
    expect_n(1);
    stall_i = 1'b0;
    step();
    step();
    #2 rst_i = 1'b1;
    #1;
    check("arst_req", {31'h0, imem_req_o}, 32'h0);
    check("arst_pc", pc_o, 32'h100);
    check("arst_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    rst_i = 1'b0;
    exp_pc = 32'h100;
    expect_n(2);
    run_drain(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
